serial_display_receiver: RTL and testbench

- Deserializes the 3-wire display stream (data, clock, latch) that the clock's display output path sends to the 74HC595 chain.
- Recovers six BCD digits plus six decimal-point bits from the 48-bit frame.
- Used as an on-chip loopback monitor for the display path, and as the front end of a slave display board.
- The serial inputs are asynchronous to i_clk; they are synchronized and edge-detected internally.

---
 rtl/serial_display_receiver.sv | 199 +++++++++++++++++++
 tb/tb_serial_display_receiver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_display_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_display_receiver
//  Description : Deserialises the 3-wire 74HC595 display stream into six BCD
//                digits with decimal points, blank and illegal-code flags.
//  Revision    : 1.0  initial release
// ============================================================================

module serial_display_receiver #(
    parameter int FRAME_BITS     = 48,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_serial_data,
    input  logic       i_serial_clk,
    input  logic       i_serial_latch,
    output logic [3:0] o_hours_msb,
    output logic [3:0] o_hours_lsb,
    output logic [3:0] o_minutes_msb,
    output logic [3:0] o_minutes_lsb,
    output logic [3:0] o_seconds_msb,
    output logic [3:0] o_seconds_lsb,
    output logic [5:0] o_dp,
    output logic [5:0] o_blank,
    output logic [5:0] o_seg_err,
    output logic       o_frame_stb,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int c_CNT_W = $clog2(FRAME_BITS + 2);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FRAME_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(FRAME_BITS + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    // Returns {blank, illegal, digit} for one {a,b,c,d,e,f,g} segment code.
    function automatic logic [5:0] f_decode(input logic [6:0] seg);
        logic [5:0] res;
        res = {1'b0, 1'b1, 4'hE};
        case (seg)
            7'h7E:   res = {2'b00, 4'h0};
            7'h30:   res = {2'b00, 4'h1};
            7'h6D:   res = {2'b00, 4'h2};
            7'h79:   res = {2'b00, 4'h3};
            7'h33:   res = {2'b00, 4'h4};
            7'h5B:   res = {2'b00, 4'h5};
            7'h5F:   res = {2'b00, 4'h6};
            7'h70:   res = {2'b00, 4'h7};
            7'h7F:   res = {2'b00, 4'h8};
            7'h7B:   res = {2'b00, 4'h9};
            7'h00:   res = {2'b10, 4'hF};
            default: res = {1'b0, 1'b1, 4'hE};
        endcase
        return res;
    endfunction

    // Synchroniser, history and registered edge-detect stages
    logic r_data_meta_q, r_data_sync_q, r_data_q;
    logic r_sclk_meta_q, r_sclk_sync_q, r_sclk_hist_q, r_sclk_rise_q;
    logic r_latch_meta_q, r_latch_sync_q, r_latch_hist_q, r_latch_rise_q;

    logic [FRAME_BITS-1:0] r_shift_q, w_shift_d;
    logic [c_CNT_W-1:0]    r_cnt_q, w_cnt_inc, w_cnt_d;
    logic [c_TMO_W-1:0]    r_tmo_q, w_tmo_d;
    logic                  w_load_d, w_bad_d;

    logic [FRAME_BITS-1:0] r_frame_q;
    logic                  r_load_q, r_bad_q;

    logic [5:0][3:0] w_digit;
    logic [5:0]      w_dp, w_blank, w_serr;

    logic [5:0][3:0] r_digit_q;
    logic [5:0]      r_dp_q, r_blank_q, r_serr_q;
    logic            r_stb_q, r_ferr_q, r_busy_q;

    // Shift and latch share one cycle so a coincident latch sees the new bit.
    always_comb begin
        w_shift_d = r_shift_q;
        w_cnt_inc = r_cnt_q;
        if (r_sclk_rise_q) begin
            w_shift_d = {r_shift_q[FRAME_BITS-2:0], r_data_q};
            if (r_cnt_q != c_CNT_SAT) begin
                w_cnt_inc = r_cnt_q + c_CNT_W'(1);
            end
        end

        w_cnt_d  = w_cnt_inc;
        w_tmo_d  = r_tmo_q;
        w_load_d = 1'b0;
        w_bad_d  = 1'b0;
        if (r_latch_rise_q) begin
            w_cnt_d = '0;
            w_tmo_d = '0;
            if (w_cnt_inc == c_CNT_FULL) begin
                w_load_d = 1'b1;
            end else begin
                w_bad_d = 1'b1;
            end
        end else if (r_sclk_rise_q || (r_cnt_q == '0)) begin
            w_tmo_d = '0;
        end else if (r_tmo_q == c_TMO_LAST) begin
            w_cnt_d = '0;
            w_tmo_d = '0;
        end else begin
            w_tmo_d = r_tmo_q + c_TMO_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            localparam int c_DP_POS = FRAME_BITS - 1 - 8 * gi;
            logic [5:0] w_dec;
            assign w_dec        = f_decode(r_frame_q[c_DP_POS-1 -: 7]);
            assign w_digit[gi]  = w_dec[3:0];
            assign w_serr[5-gi] = w_dec[4];
            assign w_blank[5-gi] = w_dec[5];
            assign w_dp[5-gi]   = r_frame_q[c_DP_POS];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data_meta_q  <= 1'b0;
            r_data_sync_q  <= 1'b0;
            r_data_q       <= 1'b0;
            r_sclk_meta_q  <= 1'b0;
            r_sclk_sync_q  <= 1'b0;
            r_sclk_hist_q  <= 1'b0;
            r_sclk_rise_q  <= 1'b0;
            r_latch_meta_q <= 1'b0;
            r_latch_sync_q <= 1'b0;
            r_latch_hist_q <= 1'b0;
            r_latch_rise_q <= 1'b0;
            r_shift_q      <= '0;
            r_cnt_q        <= '0;
            r_tmo_q        <= '0;
            r_frame_q      <= '0;
            r_load_q       <= 1'b0;
            r_bad_q        <= 1'b0;
            r_digit_q      <= '0;
            r_dp_q         <= '0;
            r_blank_q      <= '0;
            r_serr_q       <= '0;
            r_stb_q        <= 1'b0;
            r_ferr_q       <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_data_meta_q  <= i_serial_data;
            r_data_sync_q  <= r_data_meta_q;
            r_data_q       <= r_data_sync_q;
            r_sclk_meta_q  <= i_serial_clk;
            r_sclk_sync_q  <= r_sclk_meta_q;
            r_sclk_hist_q  <= r_sclk_sync_q;
            r_sclk_rise_q  <= r_sclk_sync_q & ~r_sclk_hist_q;
            r_latch_meta_q <= i_serial_latch;
            r_latch_sync_q <= r_latch_meta_q;
            r_latch_hist_q <= r_latch_sync_q;
            r_latch_rise_q <= r_latch_sync_q & ~r_latch_hist_q;

            r_shift_q <= w_shift_d;
            r_cnt_q   <= w_cnt_d;
            r_tmo_q   <= w_tmo_d;
            r_busy_q  <= (w_cnt_d != '0);
            r_load_q  <= w_load_d;
            r_bad_q   <= w_bad_d;
            if (w_load_d) begin
                r_frame_q <= w_shift_d;
            end

            r_stb_q  <= r_load_q;
            r_ferr_q <= r_bad_q;
            if (r_load_q) begin
                r_digit_q <= w_digit;
                r_dp_q    <= w_dp;
                r_blank_q <= w_blank;
                r_serr_q  <= w_serr;
            end
        end
    end

    assign o_hours_msb   = r_digit_q[0];
    assign o_hours_lsb   = r_digit_q[1];
    assign o_minutes_msb = r_digit_q[2];
    assign o_minutes_lsb = r_digit_q[3];
    assign o_seconds_msb = r_digit_q[4];
    assign o_seconds_lsb = r_digit_q[5];
    assign o_dp          = r_dp_q;
    assign o_blank       = r_blank_q;
    assign o_seg_err     = r_serr_q;
    assign o_frame_stb   = r_stb_q;
    assign o_frame_err   = r_ferr_q;
    assign o_busy        = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_display_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_display_receiver
//  Description : Scoreboard bench for serial_display_receiver with directed
//                frames and hand-computed decode results.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_serial_display_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdata, sclk, slatch;
    logic [3:0] hm, hl, mm, ml, sm, sl;
    logic [5:0] dp, blank, serr;
    logic       stb, ferr, busy;

    always #5 clk = ~clk;

    serial_display_receiver #(
        .FRAME_BITS     (48),
        .TIMEOUT_CYCLES (4096)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_serial_data  (sdata),
        .i_serial_clk   (sclk),
        .i_serial_latch (slatch),
        .o_hours_msb    (hm),
        .o_hours_lsb    (hl),
        .o_minutes_msb  (mm),
        .o_minutes_lsb  (ml),
        .o_seconds_msb  (sm),
        .o_seconds_lsb  (sl),
        .o_dp           (dp),
        .o_blank        (blank),
        .o_seg_err      (serr),
        .o_frame_stb    (stb),
        .o_frame_err    (ferr),
        .o_busy         (busy)
    );

    typedef struct packed {
        logic        is_err;
        logic [23:0] dig;
        logic [5:0]  dp;
        logic [5:0]  blank;
        logic [5:0]  serr;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat_cyc = 0;
    logic [47:0] f1, f2, f5, f7;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] mk(input logic [6:0] a, b, c, d, e, f, input logic [5:0] p);
        return {p[5], a, p[4], b, p[3], c, p[2], d, p[1], e, p[0], f};
    endfunction

    function automatic exp_t ex(input logic is_err, input logic [23:0] dg,
                                input logic [5:0] p, input logic [5:0] bl, input logic [5:0] er);
        exp_t r;
        r.is_err = is_err; r.dig = dg; r.dp = p; r.blank = bl; r.serr = er;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe or error pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (stb || ferr) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got stb=%b err=%b, expected none", stb, ferr);
                end else begin
                    e = sb.pop_front();
                    check("err_pulse", {31'd0, ferr}, {31'd0, e.is_err});
                    check("stb_pulse", {31'd0, stb}, {31'd0, ~e.is_err});
                    if (!e.is_err) check("stb_latency", cyc - lat_cyc, 32'd4);
                    check("digits", {8'd0, hm, hl, mm, ml, sm, sl}, {8'd0, e.dig});
                    check("dp", {26'd0, dp}, {26'd0, e.dp});
                    check("blank", {26'd0, blank}, {26'd0, e.blank});
                    check("seg_err", {26'd0, serr}, {26'd0, e.serr});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        sdata = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pulse_latch();
        @(negedge clk);
        lat_cyc = cyc + 1;
        slatch = 1'b1;
        repeat (4) @(negedge clk);
        slatch = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Final serial-clock rise and latch rise launched on the same edge.
    task automatic send_coincident(input logic [47:0] f);
        send_bits({16'd0, f} >> 1, 47);
        sdata = f[0];
        repeat (4) @(negedge clk);
        lat_cyc = cyc + 1;
        sclk   = 1'b1;
        slatch = 1'b1;
        repeat (4) @(negedge clk);
        sclk   = 1'b0;
        slatch = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sdata = 1'b0; sclk = 1'b0; slatch = 1'b0;
        f1 = mk(7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 6'b000000);
        f2 = mk(7'h30, 7'h6D, 7'h79, 7'h33, 7'h00, 7'h00, 6'b010100);
        f5 = mk(7'h7C, 7'h7E, 7'h7F, 7'h70, 7'h7B, 7'h5B, 6'b111111);
        f7 = mk(7'h6D, 7'h79, 7'h7E, 7'h33, 7'h70, 7'h7F, 6'b001000);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_digits", {8'd0, hm, hl, mm, ml, sm, sl}, 32'd0);
        check("reset_flags", {14'd0, dp, blank, serr}, 32'd0);
        check("reset_pulses", {29'd0, stb, ferr, busy}, 32'd0);

        // 12:34:56, no decimal points
        sb.push_back(ex(1'b0, 24'h123456, 6'b000000, 6'b000000, 6'b000000));
        send_bits({16'd0, f1}, 48);
        check("busy_full_frame", {31'd0, busy}, 32'd1);
        pulse_latch();
        check("busy_after_latch", {31'd0, busy}, 32'd0);

        // Two decimal points, blank seconds
        sb.push_back(ex(1'b0, 24'h1234FF, 6'b010100, 6'b000011, 6'b000000));
        send_bits({16'd0, f2}, 48);
        pulse_latch();

        // Short, long and empty frames keep the previous outputs
        sb.push_back(ex(1'b1, 24'h1234FF, 6'b010100, 6'b000011, 6'b000000));
        send_bits({16'd0, f2} >> 1, 47);
        pulse_latch();
        sb.push_back(ex(1'b1, 24'h1234FF, 6'b010100, 6'b000011, 6'b000000));
        send_bits({14'd0, f2, 2'b10}, 50);
        pulse_latch();
        sb.push_back(ex(1'b1, 24'h1234FF, 6'b010100, 6'b000011, 6'b000000));
        pulse_latch();

        // Illegal code 7C in hours_msb
        sb.push_back(ex(1'b0, 24'hE08795, 6'b111111, 6'b000000, 6'b100000));
        send_bits({16'd0, f5}, 48);
        pulse_latch();

        // Partial frame abandoned by timeout, then a good frame
        send_bits(64'hABCDE, 20);
        check("busy_partial", {31'd0, busy}, 32'd1);
        repeat (4096 + 10) @(negedge clk);
        check("busy_timeout", {31'd0, busy}, 32'd0);
        sb.push_back(ex(1'b0, 24'h123456, 6'b000000, 6'b000000, 6'b000000));
        send_bits({16'd0, f1}, 48);
        pulse_latch();

        // Reset mid-frame, then a frame whose last bit coincides with the latch
        send_bits(64'h2AAAAAAA, 30);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_digits", {8'd0, hm, hl, mm, ml, sm, sl}, 32'd0);
        check("midreset_flags", {13'd0, busy, dp, blank, serr}, 32'd0);
        sb.push_back(ex(1'b0, 24'h230478, 6'b001000, 6'b000000, 6'b000000));
        send_coincident(f7);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
